// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one word-wide, byte-laned memory port between an
//               instruction-fetch requester (I, read-only) and a load/store
//               requester (D, read/write). Each access is sequenced over a
//               fixed memory latency and completed with a one-cycle ready
//               pulse. Simultaneous requests are granted round-robin.
//
// Ports       : clk, rst_b        clock, synchronous active-high reset
//               i_req/i_addr      fetch request (level, held until i_ready)
//               i_ready/i_rdata   fetch completion pulse and fetched word
//               d_req/d_we/d_addr/d_wdata
//                                 load/store request (level, held until d_ready)
//               d_ready/d_rdata   load/store completion pulse and loaded word
//               mem_addr/mem_write_en/mem_data_in/mem_data_out
//                                 memory port, word aligned, lane k = [8k+7:8k]
//               busy              high whenever an access is in flight
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 4     // legal range 1..15
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ready,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ready,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_data_in,
    input  logic [XLEN-1:0] mem_data_out,
    output logic            busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic c_OWNER_I = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    localparam int                 c_CNT_W     = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT  = c_CNT_W'(MEM_LATENCY - 1);
    localparam logic [XLEN-1:0]    c_WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [1:0]         state_q,      state_d;
    logic               owner_q,      owner_d;
    logic               we_q,         we_d;
    logic [XLEN-1:0]    addr_q,       addr_d;
    logic [XLEN-1:0]    wdata_q,      wdata_d;
    logic [c_CNT_W-1:0] cnt_q,        cnt_d;
    logic               last_grant_q, last_grant_d;
    logic [XLEN-1:0]    i_rdata_q,    i_rdata_d;
    logic [XLEN-1:0]    d_rdata_q,    d_rdata_d;

    logic w_grant_i;
    logic w_grant_d;

    // Round-robin: on contention the requester that did not win last time
    // is granted; an uncontested request is granted directly.
    always_comb begin
        w_grant_i = i_req && (!d_req || (last_grant_q == c_OWNER_D));
        w_grant_d = d_req && (!i_req || (last_grant_q == c_OWNER_I));
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            c_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    // Everything the access needs is captured here, so later
                    // changes on the request inputs cannot disturb it.
                    owner_d      = w_grant_d ? c_OWNER_D : c_OWNER_I;
                    we_d         = w_grant_d && d_we;
                    addr_d       = (w_grant_d ? d_addr : i_addr) & c_WORD_MASK;
                    wdata_d      = d_wdata;
                    cnt_d        = c_CNT_INIT;
                    last_grant_d = w_grant_d ? c_OWNER_D : c_OWNER_I;
                    state_d      = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == c_OWNER_D) begin
                            d_rdata_d = mem_data_out;
                        end else begin
                            i_rdata_d = mem_data_out;
                        end
                    end
                    state_d = c_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_RESP: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q      <= c_IDLE;
            owner_q      <= c_OWNER_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= c_OWNER_D;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // The counter still holds its load value only in the first ACCESS cycle,
    // which is where the single write strobe of a store belongs.
    always_comb begin
        busy         = (state_q != c_IDLE);
        i_ready      = (state_q == c_RESP) && (owner_q == c_OWNER_I);
        d_ready      = (state_q == c_RESP) && (owner_q == c_OWNER_D);
        mem_write_en = (state_q == c_ACCESS) && we_q && (cnt_q == c_CNT_INIT);
        mem_addr     = addr_q;
        mem_data_in  = wdata_q;
        i_rdata      = i_rdata_q;
        d_rdata      = d_rdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               plus randomized traffic compared against a transaction-level
//               timing model (grant cycle + fixed offsets). A second instance
//               runs with a one-cycle memory latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance with MEM_LATENCY = 4 ----------------
    logic        rst_b, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_data_out;
    logic        i_ready, d_ready, mem_write_en, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_data_in;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    // ---------------- instance with MEM_LATENCY = 1 ----------------
    logic        rst1, i_req1, d_req1, d_we1;
    logic [31:0] i_addr1, d_addr1, d_wdata1;
    logic        i_ready1, d_ready1, mem_we1, busy1;
    logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_din1, mem_dout1;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_b(rst1),
        .i_req(i_req1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_write_en(mem_we1),
        .mem_data_in(mem_din1), .mem_data_out(mem_dout1), .busy(busy1)
    );

    // ---------------- memory environment ----------------
    logic [31:0] mem [0:255];
    logic        mem_init;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'h2402_0005;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_write_en) begin
            mem[mem_addr[9:2]] <= mem_data_in;
        end
    end

    assign mem_dout1 = mem[mem_addr1[9:2]];

    int errors = 0;
    int checks = 0;

    // ---------------- transaction-level reference model ----------------
    // An access granted in cycle s occupies the port in s+1..s+LAT, returns
    // data sampled in cycle s+LAT, and pulses ready in cycle s+LAT+1.
    int          n;
    bit          m_act, m_own, m_we, m_last_d;
    int          m_start;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] x_irdata, x_drdata;
    logic        x_busy, x_iready, x_dready, x_we, x_addr_vld;

    task automatic model_eval();
        int k;
        @(negedge clk);
        k = n - m_start;
        mem_data_out = $urandom;
        if (m_act && k == LAT && !m_we) mem_data_out = mem[m_addr[9:2]];
        x_busy     = m_act;
        x_iready   = m_act && (k == LAT + 1) && !m_own;
        x_dready   = m_act && (k == LAT + 1) && m_own;
        x_we       = m_act && (k == 1) && m_we;
        x_addr_vld = m_act && (k >= 1) && (k <= LAT);
        #1;
    endtask

    task automatic model_adv();
        int k;
        bit was_idle, gd;
        k = n - m_start;
        was_idle = !m_act;
        if (m_act && k == LAT && !m_we) begin
            if (m_own) x_drdata = mem[m_addr[9:2]];
            else       x_irdata = mem[m_addr[9:2]];
        end
        if (m_act && k == LAT + 1) m_act = 1'b0;
        if (was_idle && (i_req || d_req)) begin
            gd       = d_req && (!i_req || !m_last_d);
            m_own    = gd;
            m_we     = gd && d_we;
            m_addr   = (gd ? d_addr : i_addr) & 32'hFFFF_FFFC;
            m_wdata  = d_wdata;
            m_last_d = gd;
            m_act    = 1'b1;
            m_start  = n;
        end
        if (rst_b) begin
            m_act    = 1'b0;
            m_last_d = 1'b1;
            x_irdata = '0;
            x_drdata = '0;
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic idle(int cnt);
        repeat (cnt) begin
            model_eval();
            model_adv();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_b = 1'b1;
        idle(2);
        rst_b = 1'b0;
        model_eval();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready: got %b want 0", d_ready); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_write_en); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_data_in !== 32'h0) begin errors++; $display("FAIL reset_mem_data_in: got %h want 0", mem_data_in); end
        checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
        model_adv();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0010;
        for (int c = 0; c <= 7; c++) begin
            model_eval();
            checks++; if (busy !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL fetch_busy c=%0d: got %b", c, busy); end
            checks++; if (i_ready !== (c == 5)) begin errors++; $display("FAIL fetch_ready c=%0d: got %b", c, i_ready); end
            checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL fetch_we c=%0d: got %b want 0", c, mem_write_en); end
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr c=%0d: got %h want 10", c, mem_addr); end
            end
            if (c == 5) begin
                checks++; if (i_rdata !== 32'h2402_0005) begin errors++; $display("FAIL fetch_rdata: got %h want 24020005", i_rdata); end
            end
            model_adv();
            if (c == 5) i_req = 1'b0;
        end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0103; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= 6; c++) begin
            model_eval();
            checks++; if (mem_write_en !== (c == 1)) begin errors++; $display("FAIL store_we c=%0d: got %b", c, mem_write_en); end
            checks++; if (d_ready !== (c == 5)) begin errors++; $display("FAIL store_ready c=%0d: got %b", c, d_ready); end
            checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL store_i_ready c=%0d: got %b want 0", c, i_ready); end
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL store_addr c=%0d: got %h want 100", c, mem_addr); end
            end
            if (c == 1) begin
                checks++; if (mem_data_in[7:0] !== 8'hEF) begin errors++; $display("FAIL store_lane0: got %h want ef", mem_data_in[7:0]); end
                checks++; if (mem_data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data: got %h want deadbeef", mem_data_in); end
            end
            if (c == 6) begin
                checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_held: got %h want 0", d_rdata); end
            end
            model_adv();
            // Late input changes must not disturb the access in flight.
            if (c == 0) begin d_addr = 32'h0000_0FF0; d_wdata = 32'h1234_5678; d_we = 1'b0; end
            if (c == 5) d_req = 1'b0;
        end
    endtask

    task automatic test_alternate();
        rst_b = 1'b1;
        idle(2);
        rst_b = 1'b0;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int c = 0; c <= 24; c++) begin
            model_eval();
            checks++; if (i_ready !== (c == 5 || c == 17)) begin errors++; $display("FAIL alt_i_ready c=%0d: got %b", c, i_ready); end
            checks++; if (d_ready !== (c == 11 || c == 23)) begin errors++; $display("FAIL alt_d_ready c=%0d: got %b", c, d_ready); end
            if (c == 1 || c == 13) begin
                checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL alt_grant_i c=%0d: got %h want 10", c, mem_addr); end
            end
            if (c == 7 || c == 19) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL alt_grant_d c=%0d: got %h want 100", c, mem_addr); end
            end
            if (c == 11) begin
                checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alt_d_rdata: got %h want deadbeef", d_rdata); end
            end
            model_adv();
        end
        i_req = 1'b0; d_req = 1'b0;
        idle(8);
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int c = 0; c <= 9; c++) begin
            model_eval();
            checks++; if (d_ready !== (c == 8)) begin errors++; $display("FAIL rstmid_ready c=%0d: got %b", c, d_ready); end
            if (c == 3) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
                checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata_clr: got %h want 0", d_rdata); end
            end
            if (c == 8) begin
                checks++; if (d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_rdata: got %h want deadbeef", d_rdata); end
            end
            model_adv();
            if (c == 1) rst_b = 1'b1;
            if (c == 2) rst_b = 1'b0;
            if (c == 8) d_req = 1'b0;
        end
    endtask

    task automatic test_drop();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int c = 0; c <= 9; c++) begin
            model_eval();
            checks++; if (d_ready !== (c == 5)) begin errors++; $display("FAIL drop_ready c=%0d: got %b", c, d_ready); end
            checks++; if (busy !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL drop_busy c=%0d: got %b", c, busy); end
            if (c == 5) begin
                checks++; if (d_rdata !== 32'h2402_0005) begin errors++; $display("FAIL drop_rdata: got %h want 24020005", d_rdata); end
            end
            model_adv();
            if (c == 1) d_req = 1'b0;
        end
    endtask

    task automatic test_latency1();
        int f;
        bit want_rdy;
        rst1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst1 = 1'b0; i_req1 = 1'b1; f = 0; i_addr1 = 32'h201;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            want_rdy = (c >= 2) && ((c - 2) % 3 == 0);
            checks++; if (i_ready1 !== want_rdy) begin errors++; $display("FAIL lat1_ready c=%0d: got %b want %b", c, i_ready1, want_rdy); end
            checks++; if (busy1 !== (c % 3 != 0)) begin errors++; $display("FAIL lat1_busy c=%0d: got %b", c, busy1); end
            checks++; if ((mem_we1 | d_ready1) !== 1'b0) begin errors++; $display("FAIL lat1_we_dready c=%0d: got %b%b want 00", c, mem_we1, d_ready1); end
            if (c % 3 == 1) begin
                checks++; if (mem_addr1 !== 32'h200 + 32'(8 * f)) begin errors++; $display("FAIL lat1_addr c=%0d: got %h", c, mem_addr1); end
            end
            if (c == 1) begin
                checks++; if (mem_din1 !== 32'h0) begin errors++; $display("FAIL lat1_din: got %h want 0", mem_din1); end
            end
            if (want_rdy) begin
                checks++; if (i_rdata1 !== init_word(128 + 2 * f)) begin errors++; $display("FAIL lat1_rdata c=%0d: got %h want %h", c, i_rdata1, init_word(128 + 2 * f)); end
            end
            @(posedge clk); #1;
            if (want_rdy) begin f++; i_addr1 = 32'h201 + 32'(8 * f); end
        end
        i_req1 = 1'b0;
    endtask

    task automatic test_random();
        bit got_i, got_d;
        rst_b = 1'b0; i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 400; c++) begin
            model_eval();
            checks++; if (busy !== x_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, x_busy); end
            checks++; if (i_ready !== x_iready) begin errors++; $display("FAIL rnd_i_ready c=%0d: got %b want %b", c, i_ready, x_iready); end
            checks++; if (d_ready !== x_dready) begin errors++; $display("FAIL rnd_d_ready c=%0d: got %b want %b", c, d_ready, x_dready); end
            checks++; if (mem_write_en !== x_we) begin errors++; $display("FAIL rnd_we c=%0d: got %b want %b", c, mem_write_en, x_we); end
            checks++; if (i_rdata !== x_irdata) begin errors++; $display("FAIL rnd_i_rdata c=%0d: got %h want %h", c, i_rdata, x_irdata); end
            checks++; if (d_rdata !== x_drdata) begin errors++; $display("FAIL rnd_d_rdata c=%0d: got %h want %h", c, d_rdata, x_drdata); end
            if (x_addr_vld) begin
                checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, mem_addr, m_addr); end
            end
            if (x_we) begin
                checks++; if (mem_data_in !== m_wdata) begin errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, mem_data_in, m_wdata); end
            end
            got_i = x_iready; got_d = x_dready;
            model_adv();
            rst_b = ($urandom_range(0, 79) == 0);
            if (!i_req || got_i || $urandom_range(0, 15) == 0) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
            end
            if (!d_req || got_d || $urandom_range(0, 15) == 0) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
        end
        rst_b = 1'b0; i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        mem_init = 1'b1;
        rst_b = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_data_out = '0;
        rst1 = 1'b1; i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
        i_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;
        n = 0; m_act = 1'b0; m_own = 1'b0; m_we = 1'b0; m_last_d = 1'b1; m_start = 0;
        m_addr = '0; m_wdata = '0; x_irdata = '0; x_drdata = '0;
        @(posedge clk); #1;
        mem_init = 1'b0;

        test_reset();
        test_fetch();
        test_store();
        test_alternate();
        test_reset_mid();
        test_drop();
        test_latency1();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one word-wide, byte-laned data memory port between two requesters: instruction fetch (I, read-only) and load/store (D, read/write).
- Sequences each access over a fixed memory latency and returns read data with a one-cycle ready pulse.
- Round-robin arbitration; asserts busy so the core control stalls PC/register writeback while an access is in flight.
- Sits between the core datapath and the memory model.

Parameters:
- XLEN, 32, address and data width.
- MEM_LATENCY, 4, cycles from issue to valid mem_data_out; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; level, held until i_ready.
- i_addr  input  XLEN  fetch address.
- i_ready  output  1  one-cycle pulse: i_rdata valid.
- i_rdata  output  XLEN  fetched word.
- d_req  input  1  load/store request; level, held until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  XLEN  load/store address.
- d_wdata  input  XLEN  store data.
- d_ready  output  1  one-cycle pulse: load data valid or store done.
- d_rdata  output  XLEN  loaded word.
- mem_addr  output  XLEN  memory address, word aligned.
- mem_write_en  output  1  memory write strobe.
- mem_data_in  output  XLEN  write data; byte lane k = bits [8k+7:8k].
- mem_data_out  input  XLEN  read data, same lane mapping.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, rst_b=1 at a rising edge):
  - state=IDLE, last_grant=D.
  - i_ready, d_ready, busy, mem_write_en = 0.
  - mem_addr, mem_data_in, i_rdata, d_rdata = 0.
  - Counter = 0.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, arbitration:
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both active: grant the requester that is not last_grant.
- IDLE, on grant:
  - Latch the owner, we (forced 0 for I), addr with bits [1:0] cleared, and wdata.
  - Load counter = MEM_LATENCY-1; update last_grant; go to ACCESS.
- ACCESS:
  - mem_addr and mem_data_in are driven from the latched values.
  - mem_write_en=1 only in the first ACCESS cycle of a store; 0 otherwise.
  - Counter decrements each cycle.
  - At counter==0: register mem_data_out into the owner's rdata (loads and fetches only; rdata unchanged on stores) and go to RESP.
- RESP: owner's ready=1 for exactly this cycle, then IDLE.
- Re-arbitration happens in the following IDLE cycle.
- Latency: request seen in IDLE at cycle 0 -> ready at cycle MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+2 cycles.
- MEM_LATENCY=1: ACCESS lasts exactly one cycle.
- rdata holds its value until the next completion for the same port.
- Request dropped mid-access: the access completes; the ready pulse is still issued. The requester ignores it.
- Input changes after grant (addr/wdata/we) have no effect on the current access.
- Reset mid-access: state returns to IDLE next cycle and no ready is issued. A store whose strobe already fired is not undone.
- mem_write_en never asserts in IDLE or RESP, and never for I.
- i_ready and d_ready are never high in the same cycle.

Test Plan:
- Reset, then i_req=1, i_addr=0x0000_0010, mem returns 0x2402_0005, MEM_LATENCY=4 -> mem_addr=0x10 in cycles 1-4, i_ready=1 with i_rdata=0x2402_0005 at cycle 5, busy=1 in cycles 1-5.
- d_req=1, d_we=1, d_addr=0x0000_0103, d_wdata=0xDEAD_BEEF -> mem_addr=0x0000_0100, mem_write_en=1 in cycle 1 only, mem_data_in[7:0]=0xEF, d_ready at cycle 5, d_rdata unchanged.
- i_req and d_req held high together from reset -> grants alternate I, D, I, D. Ready pulses at cycles 5, 11, 17, 23; never both ready in one cycle.
- rst_b=1 during cycle 2 of a load -> busy=0 and state IDLE next cycle, no d_ready; next request is granted normally.
- MEM_LATENCY=1, back-to-back fetches -> i_ready every 3 cycles with the correct data.
- d_req deasserted in cycle 2 of a load -> d_ready still pulses at cycle 5; arbiter then idles.
